// File: rtl/icache_ctrl_if.sv
// Fetch, refill and flush signals shared between the instruction cache and its
// neighbours (IF stage, instruction ROM, flow controller).
interface icache_ctrl_if #(
  parameter int OFF_BITS = 2
);
  logic                       if_req_Icache_i;
  logic                       if_jump_Icache_i;
  logic [31:0]                if_addr_Icache_i;
  logic                       Icache_flush_i;
  logic                       Icache_hit_o;
  logic                       Icache_ready_o;
  logic [31:0]                Icache_inst_o;
  logic                       Icache_req_rom_o;
  logic [31:0]                Icache_addr_rom_o;
  logic                       rom_ready_i;
  logic [(32<<OFF_BITS)-1:0]  rom_data_i;

  // Cache side
  modport slave (
    input  if_req_Icache_i, if_jump_Icache_i, if_addr_Icache_i, Icache_flush_i,
           rom_ready_i, rom_data_i,
    output Icache_hit_o, Icache_ready_o, Icache_inst_o,
           Icache_req_rom_o, Icache_addr_rom_o
  );

  // Environment side (IF, ROM, flow controller)
  modport master (
    output if_req_Icache_i, if_jump_Icache_i, if_addr_Icache_i, Icache_flush_i,
           rom_ready_i, rom_data_i,
    input  Icache_hit_o, Icache_ready_o, Icache_inst_o,
           Icache_req_rom_o, Icache_addr_rom_o
  );
endinterface

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller. Serves IF fetches from the line
// array and refills a whole line from instruction ROM on a miss. At most one
// refill is in flight; a jump that arrives during a refill is parked and looked
// up again once the line has been written.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | accept fetch/jump lookups; hit delivers next cycle
// WAIT_ROM | refill request held on the ROM port until rom_ready_i
// FILL     | captured line written into the array, valid bit set
// REPLAY   | parked jump address looked up; deliver on hit, refill on miss
module icache_ctrl #(
  parameter int INDEX_BITS = 6,
  parameter int OFF_BITS   = 2
) (
  input logic          clk,
  input logic          rst_n,
  icache_ctrl_if.slave bus
);
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORD_LSB = OFF_BITS + 2;
  localparam int TAG_LSB  = INDEX_BITS + OFF_BITS + 2;
  localparam int TAG_W    = 32 - TAG_LSB;
  localparam int LINE_W   = 32 << OFF_BITS;

  typedef enum logic [1:0] {IDLE, WAIT_ROM, FILL, REPLAY} state_t;

  state_t              state;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   data_q [LINES];
  logic [LINE_W-1:0]   line_buf;
  logic [31:2]         miss_addr;
  logic [31:2]         pend_addr;
  logic                pend_q;
  logic                ready_q;
  logic [31:0]         inst_q;
  logic                req_rom_q;
  logic [31:0]         addr_rom_q;

  logic                fetch;
  logic                jump_now;
  logic [31:2]         look_addr;
  logic [INDEX_BITS-1:0] look_idx;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [OFF_BITS-1:0] look_off;
  logic [OFF_BITS-1:0] miss_off;
  logic [TAG_W-1:0]    look_tag;
  logic [TAG_W-1:0]    miss_tag;
  logic                look_hit;
  logic [31:0]         look_word;
  logic [31:0]         crit_word;
  logic                jump_pending;
  logic                unused_addr_lsb;

  assign fetch    = bus.if_req_Icache_i | bus.if_jump_Icache_i;
  assign jump_now = bus.if_jump_Icache_i;

  // In REPLAY the lookup port is borrowed by the parked jump address.
  assign look_addr = (state == REPLAY) ? pend_addr : bus.if_addr_Icache_i[31:2];
  assign look_idx  = look_addr[TAG_LSB-1:WORD_LSB];
  assign look_off  = look_addr[WORD_LSB-1:2];
  assign look_tag  = look_addr[31:TAG_LSB];
  assign miss_idx  = miss_addr[TAG_LSB-1:WORD_LSB];
  assign miss_off  = miss_addr[WORD_LSB-1:2];
  assign miss_tag  = miss_addr[31:TAG_LSB];

  // A flush in the same cycle wins over any lookup, so the cycle counts as a miss.
  assign look_hit  = valid_q[look_idx] && (tag_q[look_idx] == look_tag) && !bus.Icache_flush_i;
  assign look_word = data_q[look_idx][{look_off, 5'b0} +: 32];
  assign crit_word = bus.rom_data_i[{miss_off, 5'b0} +: 32];

  // A jump arriving in the same cycle as the line counts as already pending.
  assign jump_pending = pend_q | jump_now;

  assign unused_addr_lsb = ^bus.if_addr_Icache_i[1:0];

  assign bus.Icache_hit_o      = fetch & (state == IDLE) & look_hit;
  assign bus.Icache_ready_o    = ready_q;
  assign bus.Icache_inst_o     = inst_q;
  assign bus.Icache_req_rom_o  = req_rom_q;
  assign bus.Icache_addr_rom_o = addr_rom_q;

  // Sequencing FSM with registered outputs, valid bits and the parked jump.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      valid_q    <= '0;
      line_buf   <= '0;
      miss_addr  <= '0;
      pend_addr  <= '0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b0;
      inst_q     <= '0;
      req_rom_q  <= 1'b0;
      addr_rom_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (bus.Icache_flush_i) valid_q <= '0;
      case (state)
        IDLE: begin
          if (fetch) begin
            if (look_hit) begin
              ready_q <= 1'b1;
              inst_q  <= look_word;
            end else begin
              miss_addr  <= bus.if_addr_Icache_i[31:2];
              addr_rom_q <= {bus.if_addr_Icache_i[31:WORD_LSB], {WORD_LSB{1'b0}}};
              req_rom_q  <= 1'b1;
              state      <= WAIT_ROM;
            end
          end
        end
        WAIT_ROM: begin
          if (jump_now) begin
            pend_q    <= 1'b1;
            pend_addr <= bus.if_addr_Icache_i[31:2];
          end
          if (bus.rom_ready_i) begin
            req_rom_q <= 1'b0;
            line_buf  <= bus.rom_data_i;
            state     <= FILL;
            if (!jump_pending) begin
              ready_q <= 1'b1;
              inst_q  <= crit_word;
            end
          end
        end
        FILL: begin
          // Placed after the flush clear so the line being written survives it.
          valid_q[miss_idx] <= 1'b1;
          if (jump_now) begin
            pend_q    <= 1'b1;
            pend_addr <= bus.if_addr_Icache_i[31:2];
          end
          state <= jump_pending ? REPLAY : IDLE;
        end
        REPLAY: begin
          pend_q <= 1'b0;
          if (look_hit) begin
            ready_q <= 1'b1;
            inst_q  <= look_word;
            state   <= IDLE;
          end else begin
            miss_addr  <= pend_addr;
            addr_rom_q <= {pend_addr[31:WORD_LSB], {WORD_LSB{1'b0}}};
            req_rom_q  <= 1'b1;
            state      <= WAIT_ROM;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line and tag storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL) begin
      data_q[miss_idx] <= line_buf;
      tag_q[miss_idx]  <= miss_tag;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed scenarios followed by randomized fetch traffic,
// checked against a line-level model of cache contents and a ROM content function.
module tb_icache_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_ctrl_if #(.OFF_BITS(2)) bus ();
  icache_ctrl #(.INDEX_BITS(6), .OFF_BITS(2)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  // Model: per index, whether a line is held and which line address it is.
  bit          m_valid [64];
  logic [31:0] m_line  [64];

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & 32'hFFFF_FFF0;
  endfunction
  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 4) & 32'd63);
  endfunction
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  function automatic logic [127:0] rom_line(input logic [31:0] a);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[32*w +: 32] = rom_word(line_of(a) + 32'(4*w));
    return l;
  endfunction
  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[idx_of(a)] && (m_line[idx_of(a)] == line_of(a));
  endfunction
  function automatic void model_install(input logic [31:0] a);
    m_valid[idx_of(a)] = 1'b1;
    m_line[idx_of(a)]  = line_of(a);
  endfunction
  function automatic void model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endfunction
  function automatic logic [31:0] pool_addr();
    return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) |
           (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives an outstanding refill to completion, including any replayed jump.
  // Entered in the first WAIT_ROM cycle; leaves after the final delivery cycle.
  task automatic refill(input logic [31:0] a, input int delay, input logic [7:0] jmask,
                        input logic [31:0] ja, input bit fl);
    logic [31:0] cur, jeff;
    bit pend, done, eh;
    cur = a; pend = 0; done = 0; jeff = ja;
    while (!done) begin
      for (int c = 0; c < delay; c++) begin
        vectors++; if (bus.Icache_req_rom_o !== 1'b1 || bus.Icache_addr_rom_o !== line_of(cur)) begin miscompares++; $display("FAIL rom_hold req=%b addr=%h exp req=1 addr=%h", bus.Icache_req_rom_o, bus.Icache_addr_rom_o, line_of(cur)); end
        if (jmask[c]) begin
          if (pend) jeff = pool_addr();
          bus.if_jump_Icache_i = 1'b1; bus.if_addr_Icache_i = jeff; pend = 1;
        end else if ($urandom_range(0, 2) == 0) begin
          bus.if_req_Icache_i = 1'b1; bus.if_addr_Icache_i = pool_addr();
        end
        #1;
        vectors++; if (bus.Icache_hit_o !== 1'b0) begin miscompares++; $display("FAIL hit_busy got=%b exp=0", bus.Icache_hit_o); end
        step();
        bus.if_jump_Icache_i = 1'b0; bus.if_req_Icache_i = 1'b0;
      end
      vectors++; if (bus.Icache_req_rom_o !== 1'b1 || bus.Icache_addr_rom_o !== line_of(cur)) begin miscompares++; $display("FAIL rom_req req=%b addr=%h exp req=1 addr=%h", bus.Icache_req_rom_o, bus.Icache_addr_rom_o, line_of(cur)); end
      bus.rom_ready_i = 1'b1; bus.rom_data_i = rom_line(cur);
      step();
      bus.rom_ready_i = 1'b0; bus.rom_data_i = {$urandom, $urandom, $urandom, $urandom};
      vectors++; if (bus.Icache_req_rom_o !== 1'b0) begin miscompares++; $display("FAIL rom_drop req=%b exp=0", bus.Icache_req_rom_o); end
      vectors++; if (bus.Icache_ready_o !== !pend) begin miscompares++; $display("FAIL fill_ready got=%b exp=%b", bus.Icache_ready_o, !pend); end
      if (!pend) begin
        vectors++; if (bus.Icache_inst_o !== rom_word(cur)) begin miscompares++; $display("FAIL fill_inst addr=%h got=%h exp=%h", cur, bus.Icache_inst_o, rom_word(cur)); end
      end
      model_install(cur);
      if (!pend) begin
        if (fl) begin
          bus.Icache_flush_i = 1'b1; model_clear(); model_install(cur);
          step();
          bus.Icache_flush_i = 1'b0;
        end
        done = 1;
      end else begin
        step();
        vectors++; if (bus.Icache_ready_o !== 1'b0 || bus.Icache_req_rom_o !== 1'b0) begin miscompares++; $display("FAIL replay_quiet ready=%b req=%b exp 0 0", bus.Icache_ready_o, bus.Icache_req_rom_o); end
        eh = model_hit(jeff);
        step();
        if (eh) begin
          vectors++; if (bus.Icache_ready_o !== 1'b1 || bus.Icache_inst_o !== rom_word(jeff)) begin miscompares++; $display("FAIL replay_hit ready=%b inst=%h exp 1 %h", bus.Icache_ready_o, bus.Icache_inst_o, rom_word(jeff)); end
          done = 1;
        end else begin
          vectors++; if (bus.Icache_ready_o !== 1'b0 || bus.Icache_req_rom_o !== 1'b1 || bus.Icache_addr_rom_o !== line_of(jeff)) begin miscompares++; $display("FAIL replay_miss ready=%b req=%b addr=%h exp 0 1 %h", bus.Icache_ready_o, bus.Icache_req_rom_o, bus.Icache_addr_rom_o, line_of(jeff)); end
          cur = jeff; pend = 0; jmask = '0; delay = $urandom_range(0, 3);
        end
      end
    end
  endtask

  // One fetch (sequential or jump), optionally alongside a flush, finished through refill.
  task automatic fetch(input logic [31:0] a, input bit as_jump, input bit with_flush,
                       input int delay, input logic [7:0] jmask, input logic [31:0] ja,
                       input bit fl);
    bit eh;
    step();
    bus.if_req_Icache_i = !as_jump; bus.if_jump_Icache_i = as_jump;
    bus.if_addr_Icache_i = a; bus.Icache_flush_i = with_flush;
    #1;
    eh = with_flush ? 1'b0 : model_hit(a);
    if (with_flush) model_clear();
    vectors++; if (bus.Icache_hit_o !== eh) begin miscompares++; $display("FAIL hit addr=%h got=%b exp=%b", a, bus.Icache_hit_o, eh); end
    step();
    bus.if_req_Icache_i = 1'b0; bus.if_jump_Icache_i = 1'b0; bus.Icache_flush_i = 1'b0;
    if (eh) begin
      vectors++; if (bus.Icache_ready_o !== 1'b1 || bus.Icache_inst_o !== rom_word(a) || bus.Icache_req_rom_o !== 1'b0) begin miscompares++; $display("FAIL hit_data addr=%h ready=%b inst=%h req=%b exp 1 %h 0", a, bus.Icache_ready_o, bus.Icache_inst_o, bus.Icache_req_rom_o, rom_word(a)); end
    end else begin
      vectors++; if (bus.Icache_ready_o !== 1'b0 || bus.Icache_req_rom_o !== 1'b1 || bus.Icache_addr_rom_o !== line_of(a)) begin miscompares++; $display("FAIL miss_start addr=%h ready=%b req=%b addr_rom=%h exp 0 1 %h", a, bus.Icache_ready_o, bus.Icache_req_rom_o, bus.Icache_addr_rom_o, line_of(a)); end
      refill(a, delay, jmask, ja, fl);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.if_req_Icache_i = 1'b1; bus.if_addr_Icache_i = 32'h10;
    repeat (3) step();
    #1;
    vectors++; if (bus.Icache_hit_o !== 1'b0 || bus.Icache_ready_o !== 1'b0 || bus.Icache_req_rom_o !== 1'b0 || bus.Icache_inst_o !== 32'h0 || bus.Icache_addr_rom_o !== 32'h0) begin miscompares++; $display("FAIL reset_state hit=%b ready=%b req=%b inst=%h addr=%h exp all 0", bus.Icache_hit_o, bus.Icache_ready_o, bus.Icache_req_rom_o, bus.Icache_inst_o, bus.Icache_addr_rom_o); end
    bus.if_req_Icache_i = 1'b0;
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_cold_and_hit();
    fetch(32'h0000_0010, 0, 0, 2, 8'h00, 32'h0, 0);
    fetch(32'h0000_0014, 0, 0, 0, 8'h00, 32'h0, 0);
    fetch(32'h0000_001C, 1, 0, 0, 8'h00, 32'h0, 0);
  endtask

  task automatic test_conflict();
    fetch(32'h0000_0410, 0, 0, 1, 8'h00, 32'h0, 0);
    fetch(32'h0000_0010, 0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  task automatic test_jump_replay();
    fetch(32'h2000_0020, 0, 0, 2, 8'h01, 32'h0000_0100, 0);
    fetch(32'h2000_0024, 0, 0, 0, 8'h00, 32'h0, 0);
    fetch(32'h0000_0108, 0, 0, 0, 8'h00, 32'h0, 0);
    // Replay of an address that already hits
    fetch(32'h0000_0630, 0, 0, 3, 8'h02, 32'h0000_010C, 0);
  endtask

  task automatic test_flush_fill();
    fetch(32'h0000_0230, 0, 0, 1, 8'h00, 32'h0, 1);
    fetch(32'h0000_0234, 0, 0, 0, 8'h00, 32'h0, 0);
    fetch(32'h0000_0100, 0, 0, 0, 8'h00, 32'h0, 0);
    fetch(32'h2000_0020, 0, 0, 0, 8'h00, 32'h0, 0);
  endtask

  task automatic test_reset_mid_refill();
    step();
    bus.if_req_Icache_i = 1'b1; bus.if_addr_Icache_i = 32'h3000_0050;
    step();
    bus.if_req_Icache_i = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.Icache_req_rom_o !== 1'b0 || bus.Icache_ready_o !== 1'b0) begin miscompares++; $display("FAIL reset_mid req=%b ready=%b exp 0 0", bus.Icache_req_rom_o, bus.Icache_ready_o); end
    model_clear();
    step(); step();
    rst_n = 1'b1;
    fetch(32'h0000_0230, 0, 0, 1, 8'h00, 32'h0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 250; n++) begin
      int d;
      d = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0)
        fetch(pool_addr(), 1'($urandom_range(0, 1)), 1, d, 8'h00, 32'h0, 0);
      else
        fetch(pool_addr(), 1'($urandom_range(0, 1)), 0, d,
              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, pool_addr(),
              $urandom_range(0, 7) == 0);
    end
  endtask

  initial begin
    bus.if_req_Icache_i = 1'b0; bus.if_jump_Icache_i = 1'b0; bus.if_addr_Icache_i = '0;
    bus.Icache_flush_i = 1'b0; bus.rom_ready_i = 1'b0; bus.rom_data_i = '0;
    test_reset();
    test_cold_and_hit();
    test_conflict();
    test_jump_replay();
    test_flush_fill();
    test_reset_mid_refill();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end
endmodule
